// File: rtl/controller_fsm.sv
// Instruction-sequencing controller: latches an IIIXXXYYY word and walks it through T0..T3.
// Optional feature macro: CONTROLLER_FSM_MVACC_EN (opcode 100 becomes mvacc Rx; otherwise NOP).
module controller_fsm (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic [8:0] din,
    output logic [3:0] bus_sel,
    output logic [7:0] r_in,
    output logic       a_in,
    output logic       g_in,
    output logic       addsub,
    output logic       ir_in,
    output logic       done,
    output logic [1:0] step
);

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    localparam logic [2:0] OP_MV    = 3'b000;
    localparam logic [2:0] OP_MVI   = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
`ifdef CONTROLLER_FSM_MVACC_EN
    localparam logic [2:0] OP_MVACC = 3'b100;
`endif

    localparam logic [3:0] SEL_G      = 4'd8;
    localparam logic [3:0] SEL_A      = 4'd9;
    localparam logic [3:0] SEL_EXTERN = 4'd10;
    localparam logic [3:0] SEL_NONE   = 4'd15;

    logic [8:0] ir;
    logic [1:0] step_nxt;
    logic [2:0] opcode;
    logic [2:0] rx;
    logic [2:0] ry;
    logic [7:0] rx_onehot;

    assign opcode    = ir[8:6];
    assign rx        = ir[5:3];
    assign ry        = ir[2:0];
    assign rx_onehot = 8'h01 << rx;

    always_comb begin
        bus_sel  = SEL_NONE;
        r_in     = 8'h00;
        a_in     = 1'b0;
        g_in     = 1'b0;
        addsub   = 1'b0;
        ir_in    = 1'b0;
        done     = 1'b0;
        step_nxt = step;
        case (step)
            T0: begin
                ir_in = run;
                if (run) begin
                    step_nxt = T1;
                end
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        bus_sel  = {1'b0, ry};
                        r_in     = rx_onehot;
                        done     = 1'b1;
                        step_nxt = T0;
                    end
                    OP_MVI: begin
                        bus_sel  = SEL_EXTERN;
                        r_in     = rx_onehot;
                        done     = 1'b1;
                        step_nxt = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        bus_sel  = {1'b0, rx};
                        a_in     = 1'b1;
                        step_nxt = T2;
                    end
`ifdef CONTROLLER_FSM_MVACC_EN
                    OP_MVACC: begin
                        bus_sel  = SEL_A;
                        r_in     = rx_onehot;
                        done     = 1'b1;
                        step_nxt = T0;
                    end
`endif
                    default: begin
                        // Undefined opcodes retire as a one-step NOP.
                        done     = 1'b1;
                        step_nxt = T0;
                    end
                endcase
            end
            T2: begin
                // Only add/sub reach T2, so opcode[0] distinguishes them.
                bus_sel  = {1'b0, ry};
                g_in     = 1'b1;
                addsub   = (opcode == OP_SUB);
                step_nxt = T3;
            end
            T3: begin
                bus_sel  = SEL_G;
                r_in     = rx_onehot;
                done     = 1'b1;
                step_nxt = T0;
            end
            default: begin
                step_nxt = T0;
            end
        endcase
    end

    // State and instruction register; IR only loads on an accepted start in T0.
    always_ff @(posedge clock) begin
        if (reset) begin
            step <= T0;
            ir   <= 9'h000;
        end else begin
            step <= step_nxt;
            if (step == T0 && run) begin
                ir <= din;
            end
        end
    end

endmodule

// File: tb/tb_controller_fsm.sv
// Scoreboard bench for controller_fsm: instruction-level reference model feeds a queue checked every cycle.
module tb_controller_fsm;

    logic       clock = 1'b0;
    logic       reset;
    logic       run;
    logic [8:0] din;
    logic [3:0] bus_sel;
    logic [7:0] r_in;
    logic       a_in;
    logic       g_in;
    logic       addsub;
    logic       ir_in;
    logic       done;
    logic [1:0] step;

    controller_fsm dut (
        .clock  (clock),
        .reset  (reset),
        .run    (run),
        .din    (din),
        .bus_sel(bus_sel),
        .r_in   (r_in),
        .a_in   (a_in),
        .g_in   (g_in),
        .addsub (addsub),
        .ir_in  (ir_in),
        .done   (done),
        .step   (step)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] bus;
        logic [7:0] r;
        logic       a;
        logic       g;
        logic       as_;
        logic       ir;
        logic       dn;
        logic [1:0] st;
    } exp_t;

    exp_t sbq[$];
    exp_t plan[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic exp_t mk(input logic [3:0] bus, input logic [7:0] r, input logic a,
                                input logic g, input logic as_, input logic ir, input logic dn,
                                input logic [1:0] st);
        exp_t e;
        e.bus = bus; e.r = r; e.a = a; e.g = g; e.as_ = as_; e.ir = ir; e.dn = dn; e.st = st;
        return e;
    endfunction

    // Expand one instruction word into the output cycles it should produce after T0.
    task automatic expand(input logic [8:0] w);
        logic [2:0] op;
        logic [2:0] rx;
        logic [2:0] ry;
        logic [7:0] oh;
        op = w[8:6];
        rx = w[5:3];
        ry = w[2:0];
        oh = 8'h01 << rx;
        case (op)
            3'd0: plan.push_back(mk({1'b0, ry}, oh, 0, 0, 0, 0, 1, 2'd1));
            3'd1: plan.push_back(mk(4'd10, oh, 0, 0, 0, 0, 1, 2'd1));
            3'd2, 3'd3: begin
                plan.push_back(mk({1'b0, rx}, 8'h00, 1, 0, 0, 0, 0, 2'd1));
                plan.push_back(mk({1'b0, ry}, 8'h00, 0, 1, (op == 3'd3), 0, 0, 2'd2));
                plan.push_back(mk(4'd8, oh, 0, 0, 0, 0, 1, 2'd3));
            end
`ifdef CONTROLLER_FSM_MVACC_EN
            3'd4: plan.push_back(mk(4'd9, oh, 0, 0, 0, 0, 1, 2'd1));
`endif
            default: plan.push_back(mk(4'd15, 8'h00, 0, 0, 0, 0, 1, 2'd1));
        endcase
    endtask

    // Drive one cycle of inputs and record what the outputs must be during it.
    task automatic cyc(input logic r, input logic rn, input logic [8:0] d);
        exp_t e;
        logic idle;
        @(negedge clock);
        reset = r;
        run   = rn;
        din   = d;
        idle  = (plan.size() == 0);
        if (idle) e = mk(4'd15, 8'h00, 0, 0, 0, rn, 0, 2'd0);
        else      e = plan.pop_front();
        if (r) plan.delete();
        else if (idle && rn) expand(d);
        sbq.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        exp_t act;
        forever begin
            @(negedge clock);
            #2;
            if (sbq.size() > 0) begin
                e   = sbq.pop_front();
                act = {bus_sel, r_in, a_in, g_in, addsub, ir_in, done, step};
                n_checks++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t actual bus=%0d r=%h a=%b g=%b as=%b ir=%b done=%b step=%0d required bus=%0d r=%h a=%b g=%b as=%b ir=%b done=%b step=%0d",
                             $time, act.bus, act.r, act.a, act.g, act.as_, act.ir, act.dn, act.st,
                             e.bus, e.r, e.a, e.g, e.as_, e.ir, e.dn, e.st);
                end
                n_checks++;
                if ($countones(r_in) > 1 || (a_in && g_in)) begin
                    n_fail++;
                    $display("FAIL enable_exclusive t=%0t actual r_in=%h a_in=%b g_in=%b required at most one r_in bit and not a_in&g_in",
                             $time, r_in, a_in, g_in);
                end
            end
        end
    end

    initial begin : stim
        int k;
        reset = 1'b1;
        run   = 1'b0;
        din   = 9'h000;
        repeat (2) @(negedge clock);

        repeat (5) cyc(0, 0, 9'($urandom));
        // mv R3,R5
        cyc(0, 1, 9'b000_011_101);
        cyc(0, 0, 9'h000);
        cyc(0, 0, 9'h000);
        // sub R1,R2 with run held high (ignored until T0)
        cyc(0, 1, 9'b011_001_010);
        repeat (3) cyc(0, 1, 9'($urandom));
        cyc(0, 0, 9'h000);
        // mvi R7 then add R0,R7 back to back
        cyc(0, 1, 9'b001_111_000);
        cyc(0, 1, 9'b010_000_111);
        cyc(0, 1, 9'b010_000_111);
        repeat (3) cyc(0, 1, 9'($urandom));
        cyc(0, 0, 9'h000);
        // add R4,R4 aborted by reset in T2
        cyc(0, 1, 9'b010_100_100);
        cyc(0, 0, 9'h000);
        cyc(1, 0, 9'h000);
        repeat (3) cyc(0, 0, 9'h000);
        // opcode 100, Rx=6
        cyc(0, 1, 9'b100_110_000);
        cyc(0, 0, 9'h000);
        cyc(0, 0, 9'h000);
        // reset and run together in T0: reset wins
        cyc(1, 1, 9'b000_001_010);
        cyc(0, 0, 9'h000);

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), 9'($urandom));
        end

        k = 0;
        while (sbq.size() > 0 && k < 10) begin
            @(negedge clock);
            k++;
        end
        #4;
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain actual pending=%0d required 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
